mult_div_unit: RTL and testbench

- Multicycle signed multiply/divide engine that answers the controller's MultCtrl/DivCtrl requests.
- Operands come from registers A and B. Results feed the HI/LO registers through HICtrl/LOCtrl.
- Reports completion with a done pulse and flags divide-by-zero so the controller can take its exception path.

---
 rtl/mult_div_unit.sv | 202 ++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Multicycle signed multiply / divide engine for the HI/LO register pair.
//   Multiply uses radix-2 Booth recoding. Divide is restoring division on
//   operand magnitudes, followed by a sign fix-up.
//
// Ports
//   clock    : system clock, rising edge
//   reset    : asynchronous, active-high, clears all state
//   MultCtrl : start signed multiply (sampled only while idle, wins over DivCtrl)
//   DivCtrl  : start signed divide (sampled only while idle)
//   OpA      : multiplicand / dividend, latched on the start edge
//   OpB      : multiplier / divisor, latched on the start edge
//   HIOut    : multiply upper half / divide remainder
//   LOOut    : multiply lower half / divide quotient
//   Busy     : high while iterating
//   Done     : one-cycle pulse in the cycle HIOut/LOOut become valid
//   DivZero  : one-cycle pulse (together with Done) for a zero divisor
// ---------------------------------------------------------------------------
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             MultCtrl,
    input  logic             DivCtrl,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    output logic [WIDTH-1:0] HIOut,
    output logic [WIDTH-1:0] LOOut,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    // Booth accumulator {P_hi, P_lo, q-1}
    logic [2*WIDTH:0]   acc_q, acc_d;
    // Restoring divider: partial remainder, dividend/quotient shift register, divisor magnitude
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dsr_q, dsr_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dz_q, dz_d;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        // INT_MIN maps to 2^(WIDTH-1), which is correct as an unsigned magnitude
        return x[WIDTH-1] ? ({WIDTH{1'b0}} - x) : x;
    endfunction

    // ---------------- Booth step ----------------
    logic [WIDTH:0]   m_hi_ext;
    logic [WIDTH:0]   m_a_ext;
    logic [WIDTH:0]   m_sum;
    logic [2*WIDTH:0] m_shift;

    always_comb begin
        // Sign-extend to WIDTH+1 bits so an overflowing add keeps its true sign
        m_hi_ext = {acc_q[2*WIDTH], acc_q[2*WIDTH:WIDTH+1]};
        m_a_ext  = {a_q[WIDTH-1], a_q};
        case (acc_q[1:0])
            2'b01:   m_sum = m_hi_ext + m_a_ext;
            2'b10:   m_sum = m_hi_ext - m_a_ext;
            default: m_sum = m_hi_ext;
        endcase
        // Arithmetic shift right of {sum, P_lo, q-1}: the old q-1 falls off and
        // the extra sign bit of the sum becomes the new top bit.
        m_shift = {m_sum, acc_q[WIDTH:1]};
    end

    // ---------------- Restoring divide step ----------------
    logic [WIDTH:0]   d_shift;
    logic [WIDTH-1:0] d_trial;
    logic             d_ge;

    always_comb begin
        d_shift = {rem_q, quo_q[WIDTH-1]};
        d_ge    = (d_shift >= {1'b0, dsr_q});
        // Only used when d_ge holds, so the difference is below dsr and fits WIDTH bits
        d_trial = d_shift[WIDTH-1:0] - dsr_q;
    end

    // ---------------- Next-state logic ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;

        case (state_q)
            S_IDLE: begin
                if (MultCtrl) begin
                    a_d     = OpA;
                    b_d     = OpB;
                    acc_d   = {{WIDTH{1'b0}}, OpB, 1'b0};
                    cnt_d   = '0;
                    dz_d    = 1'b0;
                    state_d = S_MULT;
                end else if (DivCtrl) begin
                    a_d     = OpA;
                    b_d     = OpB;
                    rem_d   = '0;
                    quo_d   = mag(OpA);
                    dsr_d   = mag(OpB);
                    cnt_d   = '0;
                    dz_d    = 1'b0;
                    state_d = S_DIV;
                end
            end

            S_MULT: begin
                if (cnt_q != CW'(WIDTH)) begin
                    acc_d = m_shift;
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    hi_d    = acc_q[2*WIDTH:WIDTH+1];
                    lo_d    = acc_q[WIDTH:1];
                    state_d = S_FINISH;
                end
            end

            S_DIV: begin
                if (b_q == '0) begin
                    // Zero divisor: report and leave HI/LO untouched
                    dz_d    = 1'b1;
                    state_d = S_FINISH;
                end else if (cnt_q != CW'(WIDTH)) begin
                    rem_d = d_ge ? d_trial : d_shift[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], d_ge};
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    lo_d    = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? ({WIDTH{1'b0}} - quo_q) : quo_q;
                    hi_d    = a_q[WIDTH-1] ? ({WIDTH{1'b0}} - rem_q) : rem_q;
                    state_d = S_FINISH;
                end
            end

            default: begin
                dz_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dsr_q   <= dsr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

    // Busy covers only the cycles followed by an iteration edge; the final
    // result-load cycle and the zero-divisor cycle are excluded.
    assign Busy    = ((state_q == S_MULT) || ((state_q == S_DIV) && (b_q != '0)))
                     && (cnt_q != CW'(WIDTH));
    assign Done    = (state_q == S_FINISH);
    assign DivZero = (state_q == S_FINISH) && dz_q;
    assign HIOut   = hi_q;
    assign LOOut   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        MultCtrl = 1'b0;
    logic        DivCtrl = 1'b0;
    logic [31:0] OpA = '0;
    logic [31:0] OpB = '0;
    logic [31:0] HIOut;
    logic [31:0] LOOut;
    logic        Busy;
    logic        Done;
    logic        DivZero;

    int errors = 0;
    int checks = 0;
    int lat;
    int busy_cnt;
    int extra_done;

    always #5 clock = ~clock;

    mult_div_unit #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset   (reset),
        .MultCtrl(MultCtrl),
        .DivCtrl (DivCtrl),
        .OpA     (OpA),
        .OpB     (OpB),
        .HIOut   (HIOut),
        .LOOut   (LOOut),
        .Busy    (Busy),
        .Done    (Done),
        .DivZero (DivZero)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start an operation, scramble the operands after the start edge, and wait
    // (bounded) for Done. lat counts negedges after the start edge (1 = first
    // cycle after it); busy_cnt counts cycles with Busy high. If inject_at is
    // nonzero, DivCtrl is pulsed for one cycle at that point.
    task automatic run_op(input logic mul, input logic dv, input logic [31:0] a,
                          input logic [31:0] b, input int inject_at,
                          output int lat_o, output int busy_o);
        @(negedge clock);
        MultCtrl = mul;
        DivCtrl  = dv;
        OpA      = a;
        OpB      = b;
        @(negedge clock);
        MultCtrl = 1'b0;
        DivCtrl  = 1'b0;
        OpA      = ~a;
        OpB      = ~b;
        lat_o    = 0;
        busy_o   = 0;
        for (int n = 1; n <= 60; n++) begin
            if (n > 1) @(negedge clock);
            DivCtrl = (n == inject_at);
            if (Busy) busy_o++;
            if (Done) begin
                lat_o = n;
                break;
            end
        end
        DivCtrl = 1'b0;
    endtask

    task automatic op_check(input string tag, input logic mul, input logic dv,
                            input logic [31:0] a, input logic [31:0] b, input int inject_at,
                            input int exp_lat, input int exp_busy,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                            input logic exp_dz);
        run_op(mul, dv, a, b, inject_at, lat, busy_cnt);
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".busy"}, busy_cnt, exp_busy);
        chk({tag, ".hi"}, HIOut, exp_hi);
        chk({tag, ".lo"}, LOOut, exp_lo);
        chk({tag, ".divzero"}, DivZero, exp_dz);
        @(negedge clock);
        chk({tag, ".done_pulse"}, Done, 1'b0);
        $display("op %s a=%h b=%h -> hi=%h lo=%h lat=%0d busy=%0d", tag, a, b, HIOut, LOOut, lat, busy_cnt);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clock);
        chk("rst.hi", HIOut, 32'h0);
        chk("rst.lo", LOOut, 32'h0);
        chk("rst.busy", Busy, 1'b0);
        chk("rst.done", Done, 1'b0);
        chk("rst.divzero", DivZero, 1'b0);
        reset = 1'b0;

        // Multiplies
        op_check("mul_7x6",    1, 0, 32'd7,        32'd6,        0, 34, 32, 32'h0000_0000, 32'h0000_002A, 0);
        op_check("mul_m3x5",   1, 0, 32'hFFFF_FFFD, 32'd5,       0, 34, 32, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
        op_check("mul_min2",   1, 0, 32'h8000_0000, 32'h8000_0000, 0, 34, 32, 32'h4000_0000, 32'h0000_0000, 0);

        // Divides
        op_check("div_m17_5",  0, 1, 32'hFFFF_FFEF, 32'd5,       0, 34, 32, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0);
        op_check("div_17_m5",  0, 1, 32'd17,       32'hFFFF_FFFB, 0, 34, 32, 32'h0000_0002, 32'hFFFF_FFFD, 0);
        op_check("div_min_m1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 34, 32, 32'h0000_0000, 32'h8000_0000, 0);

        // Divide by zero keeps the preloaded 7*6 result
        op_check("pre_7x6",    1, 0, 32'd7,        32'd6,        0, 34, 32, 32'h0000_0000, 32'h0000_002A, 0);
        op_check("div_zero",   0, 1, 32'd123,      32'd0,        0, 2,  0,  32'h0000_0000, 32'h0000_002A, 1);

        // Both starts together: multiply wins
        op_check("both_2x3",   1, 1, 32'd2,        32'd3,        0, 34, 32, 32'h0000_0000, 32'h0000_0006, 0);

        // DivCtrl pulsed mid-multiply is ignored
        op_check("mul_inject", 1, 0, 32'hFFFF_FF9C, 32'd3,       10, 34, 32, 32'hFFFF_FFFF, 32'hFFFF_FED4, 0);
        extra_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (Done) extra_done++;
        end
        chk("mul_inject.extra_done", extra_done, 0);
        chk("mul_inject.idle_busy", Busy, 1'b0);
        chk("mul_inject.hold_lo", LOOut, 32'hFFFF_FED4);

        // Asynchronous reset during iteration 10 of a divide
        @(negedge clock);
        DivCtrl = 1'b1;
        OpA     = 32'd100;
        OpB     = 32'd7;
        @(posedge clock);               // start edge
        #1;
        DivCtrl = 1'b0;
        repeat (10) @(posedge clock);   // iterations 1..10
        #1;
        chk("rstmid.busy_before", Busy, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        chk("rstmid.busy", Busy, 1'b0);
        chk("rstmid.done", Done, 1'b0);
        chk("rstmid.hi", HIOut, 32'h0);
        chk("rstmid.lo", LOOut, 32'h0);
        $display("op rstmid busy=%b done=%b hi=%h lo=%h", Busy, Done, HIOut, LOOut);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        op_check("post_4x4",   1, 0, 32'd4,        32'd4,        0, 34, 32, 32'h0000_0000, 32'h0000_0010, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
